// File: rtl/baud_rate_gen_frac.sv
// Fractional baud-rate tick generator: oversample strobe (o_ticks) plus per-bit strobe (o_bit_tick).
// Latency: first o_ticks is high in the cycle after the (D + c0)-th enabled edge; all outputs are registered.
// Backpressure: none. i_div_load is a one-cycle request, and o_div_busy shows a captured divisor waiting for the next boundary.
//
// Ports:
//   i_clock       system clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_enable      run control; low holds counters/phase cleared (synchronous restart)
//   i_div_int     requested integer divisor
//   i_div_frac    requested fractional divisor (units of 1/2^FRAC_WIDTH cycle)
//   i_div_load    one-cycle capture request for i_div_int/i_div_frac
//   o_div_busy    captured divisor pending, not yet applied
//   o_ticks       oversample strobe, one-cycle pulse
//   o_bit_tick    bit strobe, coincident with every OVERSAMPLE-th o_ticks
//   o_tick_count  oversample phase, 0..OVERSAMPLE-1
module baud_rate_gen_frac #(
  parameter int DIV_WIDTH        = 16,
  parameter int FRAC_WIDTH       = 4,
  parameter int OVERSAMPLE       = 16,
  parameter int DEFAULT_DIV_INT  = 162,
  parameter int DEFAULT_DIV_FRAC = 12
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [DIV_WIDTH-1:0]          i_div_int,
  input  logic [FRAC_WIDTH-1:0]         i_div_frac,
  input  logic                          i_div_load,
  output logic                          o_div_busy,
  output logic                          o_ticks,
  output logic                          o_bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] o_tick_count
);

  localparam int CW  = DIV_WIDTH + 1;
  localparam int TCW = $clog2(OVERSAMPLE);

  logic [CW-1:0]         r_cnt;
  logic [FRAC_WIDTH-1:0] r_acc;
  logic [DIV_WIDTH-1:0]  r_div_int;
  logic [FRAC_WIDTH-1:0] r_div_frac;
  logic [DIV_WIDTH-1:0]  r_shadow_int;
  logic [FRAC_WIDTH-1:0] r_shadow_frac;
  logic                  r_busy;
  logic                  r_ticks;
  logic                  r_bit_tick;
  logic [TCW-1:0]        r_tick_count;

  logic [DIV_WIDTH-1:0]  w_div_eff;
  logic [FRAC_WIDTH:0]   w_acc_sum;
  logic                  w_carry;
  logic [CW-1:0]         w_last;
  logic                  w_boundary;
  logic                  w_tc_wrap;
  logic [TCW-1:0]        w_tc_next;

  // Divisors below 2 are clamped so o_ticks can never be high on back-to-back cycles.
  assign w_div_eff  = (r_div_int < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : r_div_int;
  // Carry out of the fractional accumulator stretches this interval by one cycle.
  assign w_acc_sum  = {1'b0, r_acc} + {1'b0, r_div_frac};
  assign w_carry    = w_acc_sum[FRAC_WIDTH];
  // Counter value on the final cycle of the interval; CW bits so D+1 cannot overflow.
  assign w_last     = CW'(w_div_eff) + CW'(w_carry) - CW'(1);
  assign w_boundary = (r_cnt == w_last);
  assign w_tc_wrap  = (r_tick_count == TCW'(OVERSAMPLE - 1));
  assign w_tc_next  = w_tc_wrap ? '0 : r_tick_count + TCW'(1);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt         <= '0;
      r_acc         <= '0;
      r_div_int     <= DIV_WIDTH'(DEFAULT_DIV_INT);
      r_div_frac    <= FRAC_WIDTH'(DEFAULT_DIV_FRAC);
      r_shadow_int  <= DIV_WIDTH'(DEFAULT_DIV_INT);
      r_shadow_frac <= FRAC_WIDTH'(DEFAULT_DIV_FRAC);
      r_busy        <= 1'b0;
      r_ticks       <= 1'b0;
      r_bit_tick    <= 1'b0;
      r_tick_count  <= '0;
    end else if (!i_enable) begin
      // Held in restart; any request (new or pending) is applied immediately.
      r_cnt        <= '0;
      r_acc        <= '0;
      r_tick_count <= '0;
      r_ticks      <= 1'b0;
      r_bit_tick   <= 1'b0;
      r_busy       <= 1'b0;
      if (i_div_load) begin
        r_div_int     <= i_div_int;
        r_div_frac    <= i_div_frac;
        r_shadow_int  <= i_div_int;
        r_shadow_frac <= i_div_frac;
      end else if (r_busy) begin
        r_div_int  <= r_shadow_int;
        r_div_frac <= r_shadow_frac;
      end
    end else if (w_boundary) begin
      r_cnt        <= '0;
      r_ticks      <= 1'b1;
      r_bit_tick   <= w_tc_wrap;
      r_tick_count <= w_tc_next;
      r_busy       <= 1'b0;
      if (i_div_load) begin
        // A request landing on the boundary bypasses the shadow wait.
        r_div_int     <= i_div_int;
        r_div_frac    <= i_div_frac;
        r_shadow_int  <= i_div_int;
        r_shadow_frac <= i_div_frac;
        r_acc         <= '0;
      end else if (r_busy) begin
        r_div_int  <= r_shadow_int;
        r_div_frac <= r_shadow_frac;
        r_acc      <= '0;
      end else begin
        r_acc <= w_acc_sum[FRAC_WIDTH-1:0];
      end
    end else begin
      r_cnt      <= r_cnt + CW'(1);
      r_ticks    <= 1'b0;
      r_bit_tick <= 1'b0;
      // Mid-interval request: park in the shadow; last request wins.
      if (i_div_load) begin
        r_shadow_int  <= i_div_int;
        r_shadow_frac <= i_div_frac;
        r_busy        <= 1'b1;
      end
    end
  end

  assign o_div_busy   = r_busy;
  assign o_ticks      = r_ticks;
  assign o_bit_tick   = r_bit_tick;
  assign o_tick_count = r_tick_count;

endmodule

// File: tb/tb_baud_rate_gen_frac.sv
// Testbench for baud_rate_gen_frac: directed scenarios plus randomized run against a reference model.
// Latency: inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: not applicable.
module tb_baud_rate_gen_frac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        busy, ticks, bit_tick;
  logic [3:0]  tick_count;

  int checks = 0;
  int errors = 0;

  baud_rate_gen_frac dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en),
    .i_div_int(div_int), .i_div_frac(div_frac), .i_div_load(div_load),
    .o_div_busy(busy), .o_ticks(ticks), .o_bit_tick(bit_tick), .o_tick_count(tick_count)
  );

  initial forever #5 clk = ~clk;

  // Reference model: countdown of cycles left in the current interval,
  // interval length computed directly from the divisor/accumulator rule.
  int m_d, m_f, m_sd, m_sf, m_acc, m_phase, m_left;
  bit m_pend;
  logic e_ticks, e_bit, e_busy;
  logic [3:0] e_phase;

  function automatic int ilen(int d, int f, int a);
    return ((d < 2) ? 2 : d) + (((a + f) >= 16) ? 1 : 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d = 162; m_f = 12; m_sd = 162; m_sf = 12; m_pend = 0;
      m_acc = 0; m_phase = 0; m_left = 0; e_ticks = 0; e_bit = 0;
    end else if (!en) begin
      m_left = 0; m_acc = 0; m_phase = 0; e_ticks = 0; e_bit = 0;
      if (div_load) begin
        m_d = int'(div_int); m_f = int'(div_frac); m_sd = m_d; m_sf = m_f;
      end else if (m_pend) begin
        m_d = m_sd; m_f = m_sf;
      end
      m_pend = 0;
    end else begin
      if (m_left == 0) m_left = ilen(m_d, m_f, m_acc);
      m_left--;
      if (m_left == 0) begin
        e_ticks = 1; e_bit = (m_phase == 15); m_phase = (m_phase + 1) % 16;
        if (div_load) begin
          m_d = int'(div_int); m_f = int'(div_frac); m_sd = m_d; m_sf = m_f;
          m_acc = 0; m_pend = 0;
        end else if (m_pend) begin
          m_d = m_sd; m_f = m_sf; m_acc = 0; m_pend = 0;
        end else begin
          m_acc = (m_acc + m_f) % 16;
        end
        m_left = ilen(m_d, m_f, m_acc);
      end else begin
        e_ticks = 0; e_bit = 0;
        if (div_load) begin
          m_sd = int'(div_int); m_sf = int'(div_frac); m_pend = 1;
        end
      end
    end
    e_busy  = m_pend;
    e_phase = 4'(m_phase);
  end

  // Cycles (falling edges) until o_ticks is seen high; -1 if the budget runs out.
  task automatic wait_tick(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (ticks === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ticks !== 1'b0) begin errors++; $display("FAIL reset_ticks got %b exp 0", ticks); end
    checks++; if (bit_tick !== 1'b0) begin errors++; $display("FAIL reset_bit_tick got %b exp 0", bit_tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (tick_count !== 4'd0) begin errors++; $display("FAIL reset_tick_count got %0d exp 0", tick_count); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({ticks, bit_tick, busy} !== 3'b000) begin errors++; $display("FAIL post_reset_outputs got %b exp 000", {ticks, bit_tick, busy}); end
    checks++; if (tick_count !== 4'd0) begin errors++; $display("FAIL post_reset_tick_count got %0d exp 0", tick_count); end
  endtask

  task automatic test_default_div;
    int n;
    en = 1'b1;
    wait_tick(400, n);
    checks++; if (n !== 162) begin errors++; $display("FAIL default_first_interval got %0d exp 162", n); end
    checks++; if (tick_count !== 4'd1) begin errors++; $display("FAIL default_tick_count got %0d exp 1", tick_count); end
    wait_tick(400, n);
    checks++; if (n !== 163) begin errors++; $display("FAIL default_second_interval got %0d exp 163", n); end
    checks++; if (tick_count !== 4'd2) begin errors++; $display("FAIL default_tick_count2 got %0d exp 2", tick_count); end
  endtask

  task automatic load_disabled(input int d, input int f);
    en = 1'b0; div_int = 16'(d); div_frac = 4'(f); div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic test_int_div;
    int n;
    load_disabled(10, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL int_load_disabled_busy got %b exp 0", busy); end
    checks++; if (tick_count !== 4'd0) begin errors++; $display("FAIL int_disabled_tick_count got %0d exp 0", tick_count); end
    en = 1'b1;
    wait_tick(40, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL int_first_interval got %0d exp 10", n); end
    for (int k = 2; k <= 33; k++) begin
      wait_tick(40, n);
      checks++; if (n !== 10) begin errors++; $display("FAIL int_interval[%0d] got %0d exp 10", k, n); end
      checks++; if (tick_count !== 4'(k % 16)) begin errors++; $display("FAIL int_tick_count[%0d] got %0d exp %0d", k, tick_count, k % 16); end
      checks++; if (bit_tick !== ((k % 16) == 0)) begin errors++; $display("FAIL int_bit_tick[%0d] got %b exp %b", k, bit_tick, (k % 16) == 0); end
    end
  endtask

  task automatic test_frac;
    int n, total;
    int lens[4] = '{10, 11, 11, 11};
    total = 0;
    load_disabled(10, 12);
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_tick(40, n);
      total += n;
      checks++; if (n !== lens[k % 4]) begin errors++; $display("FAIL frac_interval[%0d] got %0d exp %0d", k, n, lens[k % 4]); end
    end
    checks++; if (total !== 172) begin errors++; $display("FAIL frac_16_ticks_span got %0d exp 172", total); end
  endtask

  task automatic test_midload;
    int n, first_len, bc;
    load_disabled(10, 0);
    en = 1'b1;
    wait_tick(40, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL mid_first_interval got %0d exp 10", n); end
    first_len = -1; bc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
      if (ticks === 1'b1) begin
        first_len = i;
        break;
      end
      if (i == 2) begin div_int = 16'd20; div_frac = 4'd0; div_load = 1'b1; end
      if (i == 3) div_load = 1'b0;
    end
    checks++; if (first_len !== 10) begin errors++; $display("FAIL mid_current_interval got %0d exp 10", first_len); end
    checks++; if (bc !== 7) begin errors++; $display("FAIL mid_busy_cycles got %0d exp 7", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after_apply got %b exp 0", busy); end
    checks++; if (tick_count !== 4'd2) begin errors++; $display("FAIL mid_tick_count got %0d exp 2", tick_count); end
    wait_tick(40, n);
    checks++; if (n !== 20) begin errors++; $display("FAIL mid_new_interval got %0d exp 20", n); end
    checks++; if (tick_count !== 4'd3) begin errors++; $display("FAIL mid_tick_count2 got %0d exp 3", tick_count); end
    wait_tick(40, n);
    checks++; if (n !== 20) begin errors++; $display("FAIL mid_new_interval2 got %0d exp 20", n); end
  endtask

  task automatic test_boundary_load;
    int n, bc;
    bc = 0;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
      if (i == 19) begin div_int = 16'd7; div_load = 1'b1; end
    end
    @(negedge clk);
    div_load = 1'b0;
    checks++; if (ticks !== 1'b1) begin errors++; $display("FAIL bnd_tick got %b exp 1", ticks); end
    checks++; if ({bc[0], busy} !== 2'b00 || bc != 0) begin errors++; $display("FAIL bnd_busy got %0d/%b exp 0/0", bc, busy); end
    wait_tick(40, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL bnd_new_interval got %0d exp 7", n); end
    // Two requests while busy: only the second must take effect.
    @(negedge clk);
    div_int = 16'd13; div_load = 1'b1;
    @(negedge clk);
    div_int = 16'd5;
    @(negedge clk);
    div_load = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dbl_busy got %b exp 1", busy); end
    wait_tick(40, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL dbl_current_interval_rest got %0d exp 4", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dbl_busy_cleared got %b exp 0", busy); end
    wait_tick(40, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL dbl_last_wins got %0d exp 5", n); end
  endtask

  task automatic test_disable;
    int n, tc, prev;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++; if (tick_count !== 4'd0) begin errors++; $display("FAIL dis_tick_count got %0d exp 0", tick_count); end
    tc = 0;
    repeat (10) begin
      @(negedge clk);
      if (ticks === 1'b1 || bit_tick === 1'b1) tc++;
    end
    checks++; if (tc !== 0) begin errors++; $display("FAIL dis_pulses got %0d exp 0", tc); end
    en = 1'b1;
    wait_tick(40, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL reen_interval got %0d exp 5", n); end
    checks++; if (tick_count !== 4'd1) begin errors++; $display("FAIL reen_tick_count got %0d exp 1", tick_count); end
    for (int d = 0; d <= 1; d++) begin
      load_disabled(d, 0);
      en = 1'b1;
      for (int k = 0; k < 3; k++) begin
        wait_tick(10, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL clamp_d%0d_interval[%0d] got %0d exp 2", d, k, n); end
      end
      prev = 1; tc = 0;
      repeat (12) begin
        @(negedge clk);
        if (ticks === 1'b1 && prev == 1) tc++;
        prev = int'(ticks);
      end
      checks++; if (tc !== 0) begin errors++; $display("FAIL clamp_d%0d_back_to_back got %0d exp 0", d, tc); end
    end
  endtask

  task automatic test_async_reset;
    int n;
    load_disabled(9, 0);
    en = 1'b1;
    wait_tick(40, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL ar_interval got %0d exp 9", n); end
    @(negedge clk);
    @(negedge clk);
    div_int = 16'd30; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    checks++; if (busy !== 1'b1 || tick_count !== 4'd1) begin errors++; $display("FAIL ar_pre_state got busy=%b tc=%0d exp busy=1 tc=1", busy, tick_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ticks, bit_tick, busy} !== 3'b000) begin errors++; $display("FAIL ar_outputs got %b exp 000", {ticks, bit_tick, busy}); end
    checks++; if (tick_count !== 4'd0) begin errors++; $display("FAIL ar_tick_count got %0d exp 0", tick_count); end
    @(negedge clk) rst_n = 1'b1;
    wait_tick(400, n);
    checks++; if (n !== 162) begin errors++; $display("FAIL ar_default_restored got %0d exp 162", n); end
    wait_tick(400, n);
    checks++; if (n !== 163) begin errors++; $display("FAIL ar_default_second got %0d exp 163", n); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++; if (ticks !== e_ticks) begin errors++; $display("FAIL rnd_ticks@%0d got %b exp %b", i, ticks, e_ticks); end
      checks++; if (bit_tick !== e_bit) begin errors++; $display("FAIL rnd_bit_tick@%0d got %b exp %b", i, bit_tick, e_bit); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy@%0d got %b exp %b", i, busy, e_busy); end
      checks++; if (tick_count !== e_phase) begin errors++; $display("FAIL rnd_tick_count@%0d got %0d exp %0d", i, tick_count, e_phase); end
      en       = ($urandom_range(0, 19) != 0);
      div_load = ($urandom_range(0, 15) == 0);
      div_int  = 16'($urandom_range(0, 12));
      div_frac = 4'($urandom_range(0, 15));
    end
    div_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_int_div();
    test_frac();
    test_midload();
    test_boundary_load();
    test_disable();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_rate_gen_frac.md
# baud_rate_gen_frac

Parametrised, runtime-programmable baud-rate tick generator. It is the successor to `baud_rate_gen`, adding a fractional divisor, a glitch-free divisor reload handshake, an enable/restart control, and a derived per-bit tick. It sits between the system clock and the UART TX/RX blocks:
- `ticks` is the oversampling strobe consumed by the RX sampler.
- `bit_tick` marks every OVERSAMPLE-th strobe for the TX bit timer.

## Interface
- DIV_WIDTH, 16: width of the integer divisor.
- FRAC_WIDTH, 4: width of the fractional divisor; resolution is 1/2^FRAC_WIDTH cycle.
- OVERSAMPLE, 16: `ticks` pulses per `bit_tick`; must be ≥ 2.
- DEFAULT_DIV_INT, 162: integer divisor loaded at reset.
- DEFAULT_DIV_FRAC, 12: fractional divisor loaded at reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  run control; 0 holds the generator cleared.
- div_int  in  DIV_WIDTH  requested integer divisor.
- div_frac  in  FRAC_WIDTH  requested fractional divisor.
- div_load  in  1  one-cycle request to capture `div_int`/`div_frac`.
- div_busy  out  1  captured divisor pending, not yet applied.
- ticks  out  1  oversample strobe, one-cycle pulse.
- bit_tick  out  1  bit strobe, one-cycle pulse, coincident with a `ticks` pulse.
- tick_count  out  clog2(OVERSAMPLE)  oversample phase, 0..OVERSAMPLE-1.

## Operation
- State: cycle counter `cnt`, fractional accumulator `acc` (FRAC_WIDTH bits), active divisor (D, F), shadow divisor, `tick_count`.
- Clamping: an active D < 2 is treated as 2, so `ticks` is never high on two consecutive cycles.
- Interval lengths:
  - Interval k (k = 0 first after start or restart) lasts D + c_k cycles.
  - c_k is the carry out of acc_k + F, with acc_0 = 0.
  - acc_{k+1} = (acc_k + F) mod 2^FRAC_WIDTH.
  - Over 2^FRAC_WIDTH intervals, exactly F intervals are D+1 cycles long.
- Counting: `cnt` increments on each enabled edge. At the edge where `cnt` = (interval length − 1):
  - `cnt` ← 0 and `ticks` ← 1 for one cycle.
  - `acc` advances.
  - `tick_count` ← (`tick_count` + 1) mod OVERSAMPLE.
- bit_tick: `bit_tick` ← 1 on the same edge that `tick_count` wraps from OVERSAMPLE−1 to 0.
- enable = 0: on each edge, `cnt`, `acc` and `tick_count` ← 0 and `ticks`/`bit_tick` ← 0. This gives synchronous restart for RX resynchronisation. The active and shadow divisors are retained.
- Divisor reload:
  - `div_load` = 1 captures the inputs into the shadow register and sets `div_busy` on the next edge.
  - The pending shadow is applied on the next interval-boundary edge, i.e. the edge that sets `ticks`. On that edge, `acc` ← 0 and `div_busy` ← 0; `tick_count` is unaffected.
  - `div_load` while busy: the shadow is overwritten and `div_busy` stays 1. Last request wins.
  - `div_load` on a boundary edge: the new value is applied on that edge and `div_busy` remains 0.
  - `div_load` or pending load while enable = 0: applied on the next edge and `div_busy` ← 0.
- Arithmetic: `cnt` is DIV_WIDTH+1 bits so D+1 never overflows. `acc` wraps modulo 2^FRAC_WIDTH.

## Timing
- Reset (reset = 0, asynchronous):
  - `ticks`, `bit_tick`, `div_busy` = 0; `tick_count` = 0; `cnt` = 0; `acc` = 0.
  - Active and shadow divisor = (DEFAULT_DIV_INT, DEFAULT_DIV_FRAC).
  - Outputs change without a clock edge.
- Reset release: synchronous to the next rising edge; the first enabled edge is counted as `cnt` 0→1.
- First `ticks` after enable rises (or after reset with enable high) is high in the cycle following the (D + c_0)-th enabled edge.
- All outputs are registered; no combinational path from inputs to outputs.
- `div_busy` rises one cycle after `div_load` and falls on the applying edge.
- Reset mid-interval or mid-reload discards the pending shadow and the in-progress interval.

## Test plan
- Reset with enable = 0: verify all outputs 0 during reset and after release. Then enable = 1 → first `ticks` after 162 edges, next interval 163 cycles (F = 12: c = 0,1,1,1).
- Load D = 10, F = 0 while disabled; enable = 1 → `ticks` every 10 cycles; `bit_tick` every 160 cycles; `tick_count` 0→15→0.
- D = 10, F = 12 → interval lengths 10,11,11,11 repeating; exactly 16 `ticks` in 172 cycles.
- Mid-interval `div_load` (D = 20, F = 0) 3 cycles after a `ticks` while running at D = 10:
  - `div_busy` = 1 for the remaining 7 cycles.
  - The current interval stays 10 cycles; subsequent intervals are 20 cycles.
  - `tick_count` continues without a jump.
- `div_load` exactly on a boundary edge → `div_busy` never asserts and the next interval uses the new D. A second `div_load` while busy → only the last value is applied.
- Drop enable mid-interval → `tick_count` = 0 and no pulses; re-enable → first `ticks` after D edges. Assert reset mid-interval (no clock) → outputs 0 immediately. D = 0 or 1 → `ticks` every 2 cycles.
